dru_bit_collector: RTL and testbench

//  Downstream of the DRU: packs its variable-rate recovered bits (SAM[9:0],

---
 rtl/dru_pkg.sv | 12 +
 rtl/dru_bit_collector.sv | 103 ++++++++++
 tb/tb_dru_bit_collector.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dru_pkg.sv
// Shared DRU definitions: sample width, SAMV width and the matching vector types.
// Used by the bit collector, dru_tech and the word decoder.
`timescale 1ns/1ps
package dru_pkg;

   localparam int unsigned DRU_S_MAX  = 10;
   localparam int unsigned DRU_SAMV_W = 4;

   typedef logic [DRU_S_MAX-1:0]  dru_sam_t;
   typedef logic [DRU_SAMV_W-1:0] dru_samv_t;

endpackage

// File: rtl/dru_bit_collector.sv
// Packs the DRU's variable-rate recovered bits (0..S_MAX per cycle) into WORD_W-bit words.
// Optional word-boundary slip when DRU_COLLECTOR_BITSLIP_EN is defined.
`timescale 1ns/1ps
module dru_bit_collector
   import dru_pkg::*;
#(
   parameter int unsigned S_MAX  = DRU_S_MAX,
   parameter int unsigned WORD_W = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [DRU_SAMV_W-1:0] i_samv,
   input  logic [S_MAX-1:0]      i_sam,
`ifdef DRU_COLLECTOR_BITSLIP_EN
   input  logic                  i_bitslip,
`endif
   output logic                  o_valid,
   output logic [WORD_W-1:0]     o_data,
   output logic                  o_samv_err,
   output logic [4:0]            o_level
);

   localparam int unsigned ACC_W = WORD_W + S_MAX - 1;
   localparam int unsigned TOT_W = $clog2(ACC_W + 1);

   logic [ACC_W-1:0]      acc, acc_nxt;
   logic [4:0]            cnt, cnt_nxt;
   logic [WORD_W-1:0]     data_nxt;
   logic                  valid_nxt;
   logic                  err_nxt;
   logic                  legal;
   logic [DRU_SAMV_W-1:0] n;
   logic [S_MAX-1:0]      sam_eff;
   logic [S_MAX-1:0]      sam_msk;
   logic [ACC_W-1:0]      merged;
   logic [TOT_W-1:0]      tot;

`ifdef DRU_COLLECTOR_BITSLIP_EN
   logic slip_q;
   logic armed, armed_nxt;
   logic slip_now;
`endif

   always_comb begin
      legal   = i_en && (i_samv <= DRU_SAMV_W'(S_MAX));
      err_nxt = i_en && !legal;
      n       = legal ? i_samv : '0;
      sam_eff = i_sam;
`ifdef DRU_COLLECTOR_BITSLIP_EN
      // The armed slip eats the oldest bit of the first cycle that actually carries bits.
      slip_now  = armed && legal && (i_samv != '0);
      armed_nxt = armed ? !slip_now : (i_bitslip && !slip_q);
      if (slip_now) begin
         n       = n - 1'b1;
         sam_eff = i_sam >> 1;
      end
`endif
      for (int unsigned i = 0; i < S_MAX; i++) begin
         sam_msk[i] = sam_eff[i] && (DRU_SAMV_W'(i) < n);
      end
      merged = acc | (ACC_W'(sam_msk) << cnt);
      tot    = TOT_W'(cnt) + TOT_W'(n);
      if (tot >= TOT_W'(WORD_W)) begin
         valid_nxt = 1'b1;
         data_nxt  = merged[WORD_W-1:0];
         acc_nxt   = merged >> WORD_W;
         cnt_nxt   = 5'(tot - TOT_W'(WORD_W));
      end else begin
         valid_nxt = 1'b0;
         data_nxt  = o_data;
         acc_nxt   = merged;
         cnt_nxt   = 5'(tot);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc        <= '0;
         cnt        <= '0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_samv_err <= 1'b0;
`ifdef DRU_COLLECTOR_BITSLIP_EN
         slip_q     <= 1'b0;
         armed      <= 1'b0;
`endif
      end else begin
         acc        <= acc_nxt;
         cnt        <= cnt_nxt;
         o_valid    <= valid_nxt;
         o_data     <= data_nxt;
         o_samv_err <= err_nxt;
`ifdef DRU_COLLECTOR_BITSLIP_EN
         slip_q     <= i_bitslip;
         armed      <= armed_nxt;
`endif
      end
   end

   assign o_level = cnt;

endmodule

// File: tb/tb_dru_bit_collector.sv
// Scoreboard bench for dru_bit_collector: bit-queue reference model, decoupled monitor.
`timescale 1ns/1ps
module tb_dru_bit_collector;

   localparam int S_MAX  = 10;
   localparam int WORD_W = 10;

   typedef struct packed {
      logic       v;
      logic       e;
      logic [4:0] lvl;
   } st_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic [3:0]        samv;
   logic [S_MAX-1:0]  sam;
   logic              bitslip;
   logic              o_valid;
   logic [WORD_W-1:0] o_data;
   logic              o_samv_err;
   logic [4:0]        o_level;

   int total = 0;
   int bad   = 0;

   logic [WORD_W-1:0] exp_words[$];
   st_t               exp_st[$];
   bit                model_bits[$];
   bit                m_armed;
   bit                m_prev_slip;

   always #5 clk = ~clk;

   dru_bit_collector #(.S_MAX(S_MAX), .WORD_W(WORD_W)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_samv     (samv),
      .i_sam      (sam),
`ifdef DRU_COLLECTOR_BITSLIP_EN
      .i_bitslip  (bitslip),
`endif
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_samv_err (o_samv_err),
      .o_level    (o_level)
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: every accepted bit goes into one long FIFO; a word leaves whenever WORD_W bits are waiting.
   task automatic drive(bit e, int sv, logic [S_MAX-1:0] s, bit slip);
      bit   legal;
      int   n;
      int   first;
      st_t  st;
      logic [WORD_W-1:0] w;
      @(negedge clk);
      en      = e;
      samv    = 4'(sv);
      sam     = s;
      bitslip = slip;
      legal   = e && (sv <= S_MAX);
      n       = legal ? sv : 0;
      first   = 0;
`ifdef DRU_COLLECTOR_BITSLIP_EN
      if (m_armed) begin
         if (legal && sv >= 1) begin
            first   = 1;
            m_armed = 1'b0;
         end
      end else if (slip && !m_prev_slip) begin
         m_armed = 1'b1;
      end
      m_prev_slip = slip;
`endif
      for (int k = first; k < n; k++) model_bits.push_back(s[k]);
      st.v = 1'b0;
      st.e = e && (sv > S_MAX);
      if (model_bits.size() >= WORD_W) begin
         for (int k = 0; k < WORD_W; k++) w[k] = model_bits.pop_front();
         exp_words.push_back(w);
         st.v = 1'b1;
      end
      st.lvl = 5'(model_bits.size());
      exp_st.push_back(st);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      en      = 1'b0;
      bitslip = 1'b0;
      model_bits.delete();
      exp_words.delete();
      exp_st.delete();
      m_armed     = 1'b0;
      m_prev_slip = 1'b0;
      #1;
      check("rst_valid", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_err", o_samv_err, 0);
      check("rst_level", o_level, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: one status entry per stimulus cycle, one word entry per o_valid.
   always @(posedge clk) begin
      st_t st;
      #1;
      if (!rst) begin
         if (exp_st.size() > 0) begin
            st = exp_st.pop_front();
            check("valid", o_valid, st.v);
            check("samv_err", o_samv_err, st.e);
            check("level", o_level, st.lvl);
         end
         if (o_valid) begin
            if (exp_words.size() == 0) begin
               total++;
               bad++;
               $display("FAIL word_extra: got %0h want no word at %0t", o_data, $time);
            end else begin
               check("word", o_data, exp_words.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat[5];
      rst = 1'b1; en = 1'b0; samv = '0; sam = '0; bitslip = 1'b0;
      m_armed = 1'b0; m_prev_slip = 1'b0;
      #12;
      check("init_valid", o_valid, 0);
      check("init_data", o_data, 0);
      check("init_err", o_samv_err, 0);
      check("init_level", o_level, 0);
      @(negedge clk);
      rst = 1'b0;

      // full-rate words
      for (int i = 0; i < 30; i++) drive(1, 10, 10'($urandom), 0);

      // two half words, junk above samv must be masked
      drive(1, 5, {5'b11011, 5'b10101}, 0);
      drive(1, 5, {5'b10110, 5'b00111}, 0);

      // repeating legal/illegal mix
      pat = '{9, 10, 9, 11, 10};
      for (int r = 0; r < 10; r++)
         for (int j = 0; j < 5; j++) drive(1, pat[j], 10'($urandom), 0);

      // disabled input
      for (int i = 0; i < 20; i++) drive(0, $urandom_range(0, 15), 10'($urandom), 0);

      // reset discards buffered bits
      do_reset();
      drive(1, 7, 10'($urandom), 0);
      do_reset();
      drive(1, 4, 10'($urandom), 0);
      drive(1, 6, 10'($urandom), 0);

      // random traffic
      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), 10'($urandom), 0);

`ifdef DRU_COLLECTOR_BITSLIP_EN
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, 10, 10'h17C, 0);
      drive(1, 0, 10'h17C, 1);
      drive(1, 0, 10'h17C, 0);
      for (int i = 0; i < 6; i++) drive(1, 10, 10'h17C, 0);
      for (int i = 0; i < 60; i++)
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), 10'($urandom),
               $urandom_range(0, 7) == 0);
`endif

      for (int i = 0; i < 3; i++) drive(0, 0, '0, 0);
      @(negedge clk);
      @(negedge clk);
      check("words_drained", exp_words.size(), 0);
      check("status_drained", exp_st.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
